// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared register-file constants and types
package vliw_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = $clog2(NUM_REGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/vliw_reg_file_if.sv
// rtl/vliw_reg_file_if.sv - per-lane read/write buses of the shared register file
interface vliw_reg_file_if #(
  parameter int NUM_LANES = 2
);
  import vliw_pkg::*;

  logic [NUM_LANES*AW-1:0]   rs1_addr;
  logic [NUM_LANES*AW-1:0]   rs2_addr;
  logic [NUM_LANES*XLEN-1:0] rs1_data;
  logic [NUM_LANES*XLEN-1:0] rs2_data;
  logic [NUM_LANES*AW-1:0]   wr_addr;
  logic [NUM_LANES*XLEN-1:0] wr_data;
  logic [NUM_LANES-1:0]      wr_en;
  logic                      wr_conflict;
  logic [15:0]               conflict_count;
  reg_addr_t                 dbg_addr;
  xlen_t                     dbg_data;

  modport master (
    output rs1_addr, rs2_addr, wr_addr, wr_data, wr_en, dbg_addr,
    input  rs1_data, rs2_data, wr_conflict, conflict_count, dbg_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_addr, wr_data, wr_en, dbg_addr,
    output rs1_data, rs2_data, wr_conflict, conflict_count, dbg_data
  );
endinterface

// File: rtl/vliw_rf_read_port.sv
// rtl/vliw_rf_read_port.sv - one combinational read port with same-cycle write bypass
module vliw_rf_read_port
  import vliw_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                      rst_i,
  input  reg_addr_t                 addr_i,
  input  xlen_t [NUM_REGS-1:0]      regs_i,
  input  logic [NUM_LANES*AW-1:0]   wr_addr_i,
  input  logic [NUM_LANES*XLEN-1:0] wr_data_i,
  input  logic [NUM_LANES-1:0]      wr_en_i,
  output xlen_t                     data_o
);
  // Ascending scan lets the highest-index writer win, matching the commit rule.
  always_comb begin
    data_o = regs_i[addr_i];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en_i[i] && (wr_addr_i[i*AW +: AW] == addr_i)) begin
        data_o = wr_data_i[i*XLEN +: XLEN];
      end
    end
    if (rst_i || (addr_i == REG_ZERO)) begin
      data_o = '0;
    end
  end
endmodule

// File: rtl/vliw_reg_file.sv
// rtl/vliw_reg_file.sv - shared multi-lane integer register file with bypass and conflict count
module vliw_reg_file
  import vliw_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input logic            clk,
  input logic            rst,
  vliw_reg_file_if.slave rf
);
  xlen_t [NUM_REGS-1:0]  regs_q, regs_d;
  logic                  wr_conflict_q, conflict_d;
  logic [15:0]           count_q, count_d;
  xlen_t [NUM_LANES-1:0] rs1_rd, rs2_rd;

  always_comb begin
    regs_d     = regs_q;
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rf.wr_en[i] && (rf.wr_addr[i*AW +: AW] != REG_ZERO)) begin
        regs_d[rf.wr_addr[i*AW +: AW]] = rf.wr_data[i*XLEN +: XLEN];
        for (int j = 0; j < i; j++) begin
          if (rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == rf.wr_addr[i*AW +: AW])) begin
            conflict_d = 1'b1;
          end
        end
      end
    end
    regs_d[REG_ZERO] = '0;
    count_d = count_q;
    if (conflict_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q        <= '0;
      wr_conflict_q <= 1'b0;
      count_q       <= '0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= conflict_d;
      count_q       <= count_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vliw_rf_read_port #(.NUM_LANES(NUM_LANES)) u_rs1 (
      .rst_i     (rst),
      .addr_i    (rf.rs1_addr[l*AW +: AW]),
      .regs_i    (regs_q),
      .wr_addr_i (rf.wr_addr),
      .wr_data_i (rf.wr_data),
      .wr_en_i   (rf.wr_en),
      .data_o    (rs1_rd[l])
    );
    vliw_rf_read_port #(.NUM_LANES(NUM_LANES)) u_rs2 (
      .rst_i     (rst),
      .addr_i    (rf.rs2_addr[l*AW +: AW]),
      .regs_i    (regs_q),
      .wr_addr_i (rf.wr_addr),
      .wr_data_i (rf.wr_data),
      .wr_en_i   (rf.wr_en),
      .data_o    (rs2_rd[l])
    );
  end

  assign rf.rs1_data       = rs1_rd;
  assign rf.rs2_data       = rs2_rd;
  assign rf.wr_conflict    = wr_conflict_q;
  assign rf.conflict_count = count_q;
  assign rf.dbg_data       = rst ? '0 : regs_q[rf.dbg_addr];
endmodule
